// File: rtl/mux_ohs_rr.sv
// mux_ohs_rr: CH-channel valid/ready multiplexer with a registered output stage.
// The channel is chosen by round robin from the last grant, or it is forced by a
// one-hot select. A single output register drains and reloads in the same cycle,
// so a continuously ready sink sees one word per clock.
module mux_ohs_rr #(
  parameter int n  = 1,
  parameter int CH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*n-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  input  logic [CH-1:0]   ohs,
  input  logic            ohs_en,
  output logic [n-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH-1:0]   grant,
  output logic            ohs_err
);

  logic [n-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [CH-1:0] grant_q, grant_d;
  logic          ohs_err_q, ohs_err_d;

  logic          load;
  logic          ohs_legal;
  logic [CH-1:0] cand;
  logic          cand_any;
  logic [n-1:0]  sel_data;
  int            gidx;
  int            idx;

  // Candidate selection: forced one-hot channel or round robin starting after grant.
  always_comb begin
    load      = !out_valid_q || out_ready;
    ohs_legal = $onehot(ohs);
    cand      = '0;
    cand_any  = 1'b0;
    gidx      = 0;
    idx       = 0;
    for (int i = 0; i < CH; i++) begin
      if (grant_q[i]) gidx = i;
    end
    if (ohs_en) begin
      // An illegal select (zero or multi-hot) yields no candidate at all.
      if (ohs_legal && ((ohs & in_valid) != '0)) begin
        cand     = ohs;
        cand_any = 1'b1;
      end
    end else begin
      for (int k = 1; k <= CH; k++) begin
        idx = gidx + k;
        if (idx >= CH) idx = idx - CH;
        if (!cand_any && in_valid[idx]) begin
          cand[idx] = 1'b1;
          cand_any  = 1'b1;
        end
      end
    end
  end

  // Ready goes only to the candidate, only when the output register can accept.
  always_comb begin
    in_ready = (rst_n && load) ? cand : '0;
  end

  // Next-state: load on transfer, drop valid on an empty slot, otherwise hold.
  always_comb begin
    sel_data    = '0;
    for (int i = 0; i < CH; i++) begin
      if (cand[i]) sel_data = in_data[i*n +: n];
    end
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    if (load) begin
      if (cand_any) begin
        out_data_d  = sel_data;
        out_valid_d = 1'b1;
        grant_d     = cand;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    ohs_err_d = ohs_en && !ohs_legal;
  end

  // Output register; reset parks grant on the top channel so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= {1'b1, {(CH-1){1'b0}}};
      ohs_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      ohs_err_q   <= ohs_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;
  assign ohs_err   = ohs_err_q;

endmodule

// File: tb/tb_mux_ohs_rr.sv
// Bench for mux_ohs_rr (CH=4, n=8): directed scenarios plus a random round-robin run,
// with expected output words queued at drive time and popped after each clock edge.
module tb_mux_ohs_rr;
  localparam int N  = 8;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [CH-1:0]   ohs;
  logic            ohs_en;
  logic [N-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [CH-1:0]   grant;
  logic            ohs_err;

  typedef struct packed {
    logic         v;
    logic [N-1:0] d;
    logic [CH-1:0] g;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int total = 0;
  int bad   = 0;

  mux_ohs_rr #(.n(N), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ohs(ohs), .ohs_en(ohs_en), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .grant(grant), .ohs_err(ohs_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_data = 32'hA3A2A1A0; in_valid = 4'b1111;
    ohs = 4'b0000; ohs_en = 1'b0; out_ready = 1'b1;
    #2;
    step(); step();
    total++;
    if ({out_valid, out_data, grant, ohs_err} !== {1'b0, 8'h00, 4'b1000, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got v=%b d=%h g=%b err=%b want v=0 d=00 g=1000 err=0",
               out_valid, out_data, grant, ohs_err);
    end
    total++;
    if (in_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (in_ready !== 4'(1 << (k % 4))) begin
        bad++; $display("FAIL rr_in_ready[%0d]: got %b want %b", k, in_ready, 4'(1 << (k % 4)));
      end
      sbq.push_back('{1'b1, 8'hA0 + 8'(k % 4), 4'(1 << (k % 4))});
      step();
      e = sbq.pop_front(); total++;
      if ({out_valid, out_data, grant} !== e) begin
        bad++; $display("FAIL rr_out[%0d]: got v=%b d=%h g=%b want v=%b d=%h g=%b",
                        k, out_valid, out_data, grant, e.v, e.d, e.g);
      end
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1; total++;
      if (in_ready !== 4'b0000) begin
        bad++; $display("FAIL hold_in_ready[%0d]: got %b want 0000", k, in_ready);
      end
      sbq.push_back('{1'b1, 8'hA0, 4'b0001});
      step();
      e = sbq.pop_front(); total++;
      if ({out_valid, out_data, grant} !== e) begin
        bad++; $display("FAIL hold_out[%0d]: got v=%b d=%h g=%b want v=%b d=%h g=%b",
                        k, out_valid, out_data, grant, e.v, e.d, e.g);
      end
    end
    out_ready = 1'b1;
    #1; total++;
    if (in_ready !== 4'b0010) begin
      bad++; $display("FAIL hold_release_ready: got %b want 0010", in_ready);
    end
    sbq.push_back('{1'b1, 8'hA1, 4'b0010});
    step();
    e = sbq.pop_front(); total++;
    if ({out_valid, out_data, grant} !== e) begin
      bad++; $display("FAIL hold_release_out: got v=%b d=%h g=%b want v=%b d=%h g=%b",
                      out_valid, out_data, grant, e.v, e.d, e.g);
    end
  endtask

  task automatic test_forced();
    ohs_en = 1'b1; ohs = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) ohs_en = 1'b0;
      #1; total++;
      if (in_ready !== ((k == 3) ? 4'b1000 : 4'b0100)) begin
        bad++; $display("FAIL forced_ready[%0d]: got %b want %b", k, in_ready,
                        (k == 3) ? 4'b1000 : 4'b0100);
      end
      if (k == 3) sbq.push_back('{1'b1, 8'hA3, 4'b1000});
      else        sbq.push_back('{1'b1, 8'hA2, 4'b0100});
      step();
      e = sbq.pop_front(); total++;
      if ({out_valid, out_data, grant} !== e) begin
        bad++; $display("FAIL forced_out[%0d]: got v=%b d=%h g=%b want v=%b d=%h g=%b",
                        k, out_valid, out_data, grant, e.v, e.d, e.g);
      end
    end
  endtask

  task automatic test_illegal_select();
    logic [CH-1:0] sel_tab [3] = '{4'b0110, 4'b0000, 4'b0000};
    logic          en_tab  [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      ohs = sel_tab[k]; ohs_en = en_tab[k];
      #1; total++;
      if (in_ready !== ((k == 2) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL illegal_ready[%0d]: got %b want %b", k, in_ready,
                        (k == 2) ? 4'b0001 : 4'b0000);
      end
      if (k == 2) sbq.push_back('{1'b1, 8'hA0, 4'b0001});
      else        sbq.push_back('{1'b0, 8'hA3, 4'b1000});
      step();
      e = sbq.pop_front(); total++;
      if ({out_valid, out_data, grant} !== e) begin
        bad++; $display("FAIL illegal_out[%0d]: got v=%b d=%h g=%b want v=%b d=%h g=%b",
                        k, out_valid, out_data, grant, e.v, e.d, e.g);
      end
      total++;
      if (ohs_err !== (k != 2)) begin
        bad++; $display("FAIL illegal_err[%0d]: got %b want %b", k, ohs_err, (k != 2));
      end
    end
  endtask

  task automatic test_idle();
    in_valid = 4'b0000;
    #1; total++;
    if (in_ready !== 4'b0000) begin
      bad++; $display("FAIL idle_ready: got %b want 0000", in_ready);
    end
    sbq.push_back('{1'b0, 8'hA0, 4'b0001});
    step();
    e = sbq.pop_front(); total++;
    if ({out_valid, out_data, grant} !== e) begin
      bad++; $display("FAIL idle_out: got v=%b d=%h g=%b want v=%b d=%h g=%b",
                      out_valid, out_data, grant, e.v, e.d, e.g);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 4'b1111;
    step();
    total++;
    if ({out_valid, out_data, grant} !== {1'b1, 8'hA1, 4'b0010}) begin
      bad++; $display("FAIL rstmid_pre: got v=%b d=%h g=%b want v=1 d=a1 g=0010",
                      out_valid, out_data, grant);
    end
    #2; rst_n = 1'b0;
    #1; total++;
    if ({out_valid, out_data, grant, in_ready} !== {1'b0, 8'h00, 4'b1000, 4'b0000}) begin
      bad++; $display("FAIL rstmid_async: got v=%b d=%h g=%b rdy=%b want v=0 d=00 g=1000 rdy=0000",
                      out_valid, out_data, grant, in_ready);
    end
    step();
    rst_n = 1'b1; in_valid = 4'b1010;
    #1; total++;
    if (in_ready !== 4'b0010) begin
      bad++; $display("FAIL rstmid_ready: got %b want 0010", in_ready);
    end
    sbq.push_back('{1'b1, 8'hA1, 4'b0010});
    step();
    e = sbq.pop_front(); total++;
    if ({out_valid, out_data, grant} !== e) begin
      bad++; $display("FAIL rstmid_out: got v=%b d=%h g=%b want v=%b d=%h g=%b",
                      out_valid, out_data, grant, e.v, e.d, e.g);
    end
  endtask

  task automatic test_back_to_back();
    logic          m_v = 1'b1;
    logic [N-1:0]  m_d = 8'hA1;
    int            m_gi = 1;
    int            c;
    logic [CH-1:0] exp_rdy;
    for (int k = 0; k < 40; k++) begin
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      #1;
      c = -1;
      exp_rdy = 4'b0000;
      if (!m_v || out_ready) begin
        for (int s = 1; s <= CH; s++) begin
          if (c < 0 && in_valid[(m_gi + s) % CH]) c = (m_gi + s) % CH;
        end
        if (c >= 0) begin
          exp_rdy = 4'(1 << c);
          m_v = 1'b1; m_d = in_data[c*N +: N]; m_gi = c;
        end else begin
          m_v = 1'b0;
        end
      end
      total++;
      if (in_ready !== exp_rdy) begin
        bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, in_ready, exp_rdy);
      end
      sbq.push_back('{m_v, m_d, 4'(1 << m_gi)});
      step();
      e = sbq.pop_front(); total++;
      if ({out_valid, out_data, grant, ohs_err} !== {e, 1'b0}) begin
        bad++; $display("FAIL b2b_out[%0d]: got v=%b d=%h g=%b err=%b want v=%b d=%h g=%b err=0",
                        k, out_valid, out_data, grant, ohs_err, e.v, e.d, e.g);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_forced();
    test_illegal_select();
    test_idle();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
